// File: rtl/axi_burst_reader.sv
// axi_burst_reader: single-outstanding AXI read burst engine that streams 512-bit beats to a consumer.
// Optional macro RD_ERR_CHECK_EN enables sticky rresp/rlast error detection on err.
module axi_burst_reader #(
  parameter int          MAX_BURST = 16,
  parameter logic [15:0] RD_ID     = 16'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [63:0]  base_addr,
  input  logic [31:0]  num_words,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [511:0] data_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic [15:0]  arid_m,
  output logic [63:0]  araddr_m,
  output logic [7:0]   arlen_m,
  output logic [2:0]   arsize_m,
  output logic         arvalid_m,
  input  logic         arready_m,
  input  logic [15:0]  rid_m,
  input  logic [511:0] rdata_m,
  input  logic [1:0]   rresp_m,
  input  logic         rlast_m,
  input  logic         rvalid_m,
  output logic         rready_m
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  localparam logic [8:0] BURST_CAP = 9'(MAX_BURST);

  state_t      state, state_next;
  logic [63:0] cur_addr;
  logic [31:0] remaining;
  logic [8:0]  beat_cnt;
  logic [8:0]  rem_beats, page_beats, beats;
  logic        start_ok, ar_hs, r_hs;
  logic        unused_bits;

  // Burst length is the smallest of what is left, the burst cap and the room before the next 4 KB page.
  always_comb begin
    rem_beats  = (remaining > {23'd0, BURST_CAP}) ? BURST_CAP : remaining[8:0];
    page_beats = 9'd64 - {3'd0, cur_addr[11:6]};
    beats      = (rem_beats < page_beats) ? rem_beats : page_beats;
  end

  assign start_ok    = (state == IDLE) && start;
  assign ar_hs       = (state == ADDR) && arready_m;
  assign r_hs        = (state == DATA) && rvalid_m && data_ready;
  assign unused_bits = ^{rid_m, rresp_m, rlast_m};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    arvalid_m  = 1'b0;
    araddr_m   = 64'd0;
    arlen_m    = 8'd0;
    arsize_m   = 3'd0;
    arid_m     = 16'd0;
    rready_m   = 1'b0;
    data_valid = 1'b0;
    data_out   = '0;
    case (state)
      IDLE: begin
        if (start) state_next = (num_words == 32'd0) ? DONE : ADDR;
      end
      ADDR: begin
        arvalid_m = 1'b1;
        araddr_m  = cur_addr;
        arlen_m   = 8'(beats - 9'd1);
        arsize_m  = 3'd6;
        arid_m    = RD_ID;
        if (arready_m) state_next = DATA;
      end
      DATA: begin
        // Pure pass-through: consumer back-pressure goes straight to memory.
        rready_m   = data_ready;
        data_valid = rvalid_m;
        data_out   = rdata_m;
        if (r_hs && beat_cnt == 9'd1) state_next = (remaining != 32'd0) ? ADDR : DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr  <= 64'd0;
      remaining <= 32'd0;
      beat_cnt  <= 9'd0;
    end else if (start_ok && num_words != 32'd0) begin
      cur_addr  <= {base_addr[63:6], 6'b0};
      remaining <= num_words;
    end else if (ar_hs) begin
      cur_addr  <= cur_addr + {49'd0, beats, 6'd0};
      remaining <= remaining - {23'd0, beats};
      beat_cnt  <= beats;
    end else if (r_hs) begin
      beat_cnt  <= beat_cnt - 9'd1;
    end
  end

`ifdef RD_ERR_CHECK_EN
  // Sticky until the next accepted start; the transfer itself is never aborted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           err <= 1'b0;
    else if (start_ok) err <= 1'b0;
    else if (r_hs && (rresp_m != 2'b00 || rlast_m != (beat_cnt == 9'd1))) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_burst_reader.sv
// tb_axi_burst_reader: directed bench with an AXI memory responder and a transfer-level reference model.
// Expected err behaviour follows whether RD_ERR_CHECK_EN is defined for the build.
module tb_axi_burst_reader;

  localparam int          MAXB = 16;
  localparam logic [15:0] RID  = 16'h0005;
`ifdef RD_ERR_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [63:0]  base_addr = 64'd0;
  logic [31:0]  num_words = 32'd0;
  logic         busy, done, err;
  logic [511:0] data_out;
  logic         data_valid;
  logic         data_ready = 1'b0;
  logic [15:0]  arid_m;
  logic [63:0]  araddr_m;
  logic [7:0]   arlen_m;
  logic [2:0]   arsize_m;
  logic         arvalid_m;
  logic         arready_m;
  logic [15:0]  rid_m;
  logic [511:0] rdata_m;
  logic [1:0]   rresp_m;
  logic         rlast_m;
  logic         rvalid_m;
  logic         rready_m;

  int checks = 0;
  int failures = 0;

  axi_burst_reader #(.MAX_BURST(MAXB), .RD_ID(RID)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .err(err),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
    .arvalid_m(arvalid_m), .arready_m(arready_m),
    .rid_m(rid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m),
    .rvalid_m(rvalid_m), .rready_m(rready_m)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] word_of(input logic [63:0] a);
    logic [511:0] w;
    for (int k = 0; k < 8; k++) w[k*64 +: 64] = a ^ (64'h0123_4567_89AB_CDEF * 64'(k + 1));
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: stalls AR by ar_delay cycles, then streams one burst of address-derived words.
  int          ar_delay = 0;
  int          err_at = -1;
  int          ar_wait;
  int          r_left;
  int          beats_total;
  logic [63:0] r_addr;
  logic        r_active;

  assign rid_m   = 16'h00FF;
  assign rdata_m = rvalid_m ? word_of(r_addr) : '0;
  assign rlast_m = rvalid_m && (r_left == 1);
  assign rresp_m = (rvalid_m && beats_total == err_at) ? 2'd2 : 2'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      arready_m   <= 1'b0;
      rvalid_m    <= 1'b0;
      r_active    <= 1'b0;
      r_addr      <= 64'd0;
      r_left      <= 0;
      ar_wait     <= 0;
      beats_total <= 0;
    end else begin
      if (arvalid_m && arready_m) begin
        arready_m <= 1'b0;
        ar_wait   <= 0;
        r_active  <= 1'b1;
        r_addr    <= araddr_m;
        r_left    <= int'(arlen_m) + 1;
      end else if (arvalid_m) begin
        if (ar_wait >= ar_delay) arready_m <= 1'b1;
        else                     ar_wait   <= ar_wait + 1;
      end
      if (r_active) begin
        if (!rvalid_m) rvalid_m <= 1'b1;
        else if (rready_m) begin
          beats_total <= beats_total + 1;
          r_addr      <= r_addr + 64'd64;
          r_left      <= r_left - 1;
          if (r_left == 1) begin
            r_active <= 1'b0;
            rvalid_m <= 1'b0;
          end
        end
      end
    end
  end

  // Reference model: the list of bursts and words a transfer must produce.
  logic [63:0]  exp_ar_addr[$];
  logic [7:0]   exp_ar_len[$];
  logic [511:0] exp_words[$];

  task automatic build_expect(input logic [63:0] base, input logic [31:0] n);
    logic [63:0]     a;
    longint unsigned rem, room, b;
    a   = {base[63:6], 6'b0};
    rem = longint'(n);
    while (rem > 0) begin
      room = (4096 - (a % 4096)) / 64;
      b = rem;
      if (b > MAXB) b = MAXB;
      if (b > room) b = room;
      exp_ar_addr.push_back(a);
      exp_ar_len.push_back(8'(b - 1));
      for (longint unsigned i = 0; i < b; i++) exp_words.push_back(word_of(a + 64 * i));
      a   = a + 64 * b;
      rem = rem - b;
    end
  endtask

  int phase = 0;
  bit err_model = 1'b0;
  bit ar_due = 1'b0;
  int words_got = 0;
  int ars_seen = 0;
  int done_count = 0;

  // Per-cycle comparison against the model; phase 0 idle, 1 transferring, 2 completion cycle.
  initial begin
    bit last_hs;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0;
        err_model = 1'b0;
        ar_due = 1'b0;
      end else begin
        checkOutput("done", done, phase == 2);
        checkOutput("busy", busy, phase != 0);
        checkOutput("err", err, ERR_ON ? err_model : 1'b0);
        checkOutput("data_valid", data_valid, rvalid_m);
        checkOutput("rready", rready_m, r_active ? data_ready : 1'b0);
        if (ar_due) checkOutput("ar_issue_timing", arvalid_m, 1'b1);
        ar_due = 1'b0;
        if (arvalid_m) begin
          checkOutput("ar_during_burst", r_active, 1'b0);
          if (exp_ar_addr.size() == 0) checkOutput("ar_unexpected", arvalid_m, 1'b0);
          else begin
            checkOutput("araddr", araddr_m, exp_ar_addr[0]);
            checkOutput("arlen", arlen_m, exp_ar_len[0]);
            checkOutput("arsize", arsize_m, 3'd6);
            checkOutput("arid", arid_m, RID);
            if (arready_m) begin
              void'(exp_ar_addr.pop_front());
              void'(exp_ar_len.pop_front());
              ars_seen++;
            end
          end
        end
        last_hs = 1'b0;
        if (rvalid_m && rready_m) begin
          if (rresp_m != 2'd0) err_model = 1'b1;
          if (exp_words.size() == 0) checkOutput("beat_unexpected", rready_m, 1'b0);
          else begin
            checkOutput("data_out", data_out, exp_words[0]);
            void'(exp_words.pop_front());
            words_got++;
          end
          if (r_left == 1) begin
            if (exp_words.size() == 0) last_hs = 1'b1;
            else ar_due = 1'b1;
          end
        end
        case (phase)
          0: if (start) begin
            err_model = 1'b0;
            phase = (num_words == 32'd0) ? 2 : 1;
            if (num_words != 32'd0) ar_due = 1'b1;
          end
          1: if (last_hs) phase = 2;
          default: begin
            phase = 0;
            done_count++;
          end
        endcase
      end
    end
  end

  bit ready_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic applyStimulus(input logic [63:0] base, input logic [31:0] n, input int mode,
                               input int delay, input int err_rel, input bit poke, input int exp_ars);
    int w0, a0, d0, cyc;
    w0 = words_got;
    a0 = ars_seen;
    d0 = done_count;
    ar_delay = delay;
    err_at = (err_rel < 0) ? -1 : beats_total + err_rel;
    @(posedge clk); #1;
    base_addr = base;
    num_words = n;
    start = 1'b1;
    data_ready = (mode == 0) ? 1'b1 : ready_pat[0];
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (phase != 0 && cyc < 3000) begin
      data_ready = (mode == 0) ? 1'b1 : ready_pat[cyc % 4];
      if (poke && cyc == 6) begin
        start = 1'b1;
        num_words = 32'd3;
      end else start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 3000) begin
      checkOutput("transfer_timeout", 1'b1, 1'b0);
      exp_ar_addr.delete();
      exp_ar_len.delete();
      exp_words.delete();
    end
    checkOutput("words_delivered", 32'(words_got - w0), n);
    checkOutput("ar_count", 32'(ars_seen - a0), 32'(exp_ars));
    checkOutput("done_count", 32'(done_count - d0), 32'd1);
    checkOutput("words_left", 32'(exp_words.size()), 32'd0);
    err_at = -1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_err", err, 1'b0);
    checkOutput("reset_arvalid", arvalid_m, 1'b0);
    checkOutput("reset_araddr", araddr_m, 64'd0);
    checkOutput("reset_arlen", arlen_m, 8'd0);
    checkOutput("reset_arsize", arsize_m, 3'd0);
    checkOutput("reset_arid", arid_m, 16'd0);
    checkOutput("reset_rready", rready_m, 1'b0);
    checkOutput("reset_data_valid", data_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] single burst of 4");
    build_expect(64'h0, 32'd4);
    checkOutput("pin1_len", exp_ar_len[0], 8'd3);
    applyStimulus(64'h0, 32'd4, 0, 0, -1, 1'b0, 1);

    $display("[TB] 40 words split into three bursts");
    build_expect(64'h0, 32'd40);
    checkOutput("pin2_n", 32'(exp_ar_addr.size()), 32'd3);
    checkOutput("pin2_a1", exp_ar_addr[1], 64'h400);
    checkOutput("pin2_a2", exp_ar_addr[2], 64'h800);
    checkOutput("pin2_l0", exp_ar_len[0], 8'd15);
    checkOutput("pin2_l2", exp_ar_len[2], 8'd7);
    applyStimulus(64'h0, 32'd40, 0, 0, -1, 1'b0, 3);

    $display("[TB] 4 KB boundary with unaligned low bits");
    build_expect(64'hFD5, 32'd4);
    checkOutput("pin3_a0", exp_ar_addr[0], 64'hFC0);
    checkOutput("pin3_l0", exp_ar_len[0], 8'd0);
    checkOutput("pin3_a1", exp_ar_addr[1], 64'h1000);
    checkOutput("pin3_l1", exp_ar_len[1], 8'd2);
    applyStimulus(64'hFD5, 32'd4, 0, 0, -1, 1'b0, 2);

    $display("[TB] back-pressure, slow arready, start while busy");
    build_expect(64'h2000, 32'd8);
    applyStimulus(64'h2000, 32'd8, 1, 5, -1, 1'b1, 1);

    $display("[TB] zero-length request");
    applyStimulus(64'h40, 32'd0, 0, 0, -1, 1'b0, 0);

    $display("[TB] address wrap at top of memory");
    build_expect(64'hFFFF_FFFF_FFFF_FFC0, 32'd2);
    checkOutput("pin4_a1", exp_ar_addr[1], 64'h0);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFC0, 32'd2, 0, 0, -1, 1'b0, 2);

    $display("[TB] error response on beat 2 of 4");
    build_expect(64'h3000, 32'd4);
    applyStimulus(64'h3000, 32'd4, 0, 1, 1, 1'b0, 1);
    checkOutput("err_sticky", err, ERR_ON);
    applyStimulus(64'h0, 32'd0, 0, 0, -1, 1'b0, 0);
    checkOutput("err_cleared", err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
